// File: rtl/ram_stream_reader_pkg.sv
// Shared state encoding for the RAM stream reader.
package ram_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry valid/ready buffer holding words returned by the RAM.
// Head entry drives the output directly, so data is stable while stalled.
module stream_skid_buffer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  push;
  logic                  pop;

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = head_q;

  // Next-state of the two entries; flush discards everything held.
  always_comb begin
    push   = in_valid && in_ready;
    pop    = out_valid && out_ready;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) head_d = in_data;
          else               tail_d = in_data;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          head_d = tail_q;
          cnt_d  = cnt_q - 2'd1;
        end
        // Push only happens below full, so a simultaneous pop leaves one entry.
        2'b11: head_d = in_data;
        default: ;
      endcase
    end
  end

  // Entry and occupancy registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/ram_stream_reader.sv
// Reads a burst of consecutive words from a 1-cycle-latency RAM and streams
// them out over valid/ready. Reads are issued only when the output buffer is
// guaranteed to have room for the returning word.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic [ADDR_WIDTH-1:0] addr_r,
  input  logic [DATA_WIDTH-1:0] ram_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
  logic [ADDR_WIDTH:0]   issue_left_q, issue_left_d;
  logic [ADDR_WIDTH:0]   beat_left_q, beat_left_d;
  logic                  rd_vld_p1_q, rd_vld_p1_d;
  logic                  done_q, done_d;
  logic                  issue;
  logic                  pop;
  logic                  flush;
  logic                  buf_in_ready;
  logic [1:0]            used;

  // Words held in the buffer plus the one possibly in flight from the RAM.
  assign used   = {1'b0, out_valid} + {1'b0, ~buf_in_ready} + {1'b0, rd_vld_p1_q};
  assign pop    = out_valid && out_ready;
  assign addr_r = issue ? rd_addr_q : last_addr_q;
  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;

  // Burst control: start capture, read issue, beat counting, abort.
  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    last_addr_d  = last_addr_q;
    issue_left_d = issue_left_q;
    beat_left_d  = beat_left_q;
    done_d       = 1'b0;
    flush        = 1'b0;
    issue        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          rd_addr_d    = base_addr;
          issue_left_d = length;
          beat_left_d  = length;
          if (length == '0) begin
            state_d = ST_FLUSH;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d      = ST_IDLE;
          flush        = 1'b1;
          issue_left_d = '0;
          beat_left_d  = '0;
        end else begin
          if ((issue_left_q != '0) && ((used < 2'd2) || (pop && (used == 2'd2)))) begin
            issue        = 1'b1;
            last_addr_d  = rd_addr_q;
            rd_addr_d    = rd_addr_q + ADDR_ONE;
            issue_left_d = issue_left_q - LEN_ONE;
          end
          if (pop) begin
            beat_left_d = beat_left_q - LEN_ONE;
            if (beat_left_q == LEN_ONE) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    rd_vld_p1_d = issue;
  end

  // Control and address registers; p1 marks a RAM word arriving next edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      rd_addr_q    <= '0;
      last_addr_q  <= '0;
      issue_left_q <= '0;
      beat_left_q  <= '0;
      rd_vld_p1_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      last_addr_q  <= last_addr_d;
      issue_left_q <= issue_left_d;
      beat_left_q  <= beat_left_d;
      rd_vld_p1_q  <= rd_vld_p1_d;
      done_q       <= done_d;
    end
  end

  // p1 -> output: RAM word captured into the buffer one cycle after issue.
  stream_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .in_valid (rd_vld_p1_q),
    .in_ready (buf_in_ready),
    .in_data  (ram_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader with a registered-read RAM model and scoreboard.
module tb_ram_stream_reader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [11:0] base_addr = '0;
  logic [12:0] length = '0;
  logic [11:0] addr_r;
  logic [7:0]  ram_data = '0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        done;

  logic [7:0]  mem [0:4095];
  logic [7:0]  sb [$];

  int total = 0;
  int bad = 0;
  int beat_cnt = 0;
  int done_cnt = 0;
  bit mon_en = 1'b1;
  bit prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic [7:0] exp_b;

  typedef struct {
    logic [11:0] base;
    logic [12:0] len;
    int          mode;         // 0 ready high, 1 hold-off then toggle, 2 random
    int          abort_after;  // -1: never abort
    int          exp_beats;
    int          exp_done;
  } vec_t;

  vec_t vecs [7];

  ram_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(12)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .abort    (abort),
    .base_addr(base_addr),
    .length   (length),
    .addr_r   (addr_r),
    .ram_data (ram_data),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 4096; i++) mem[i] = 8'(i & 255);

  // Registered-read RAM: data for addr_r appears after the next edge.
  always @(posedge clk) ram_data <= mem[addr_r];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Beats are recorded mid-cycle; they transfer on the following rising edge.
  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      if (done) done_cnt++;
      if (prev_stall) begin
        total++;
        if (!(out_valid && out_data == prev_data)) begin
          bad++;
          $display("FAIL stall_hold: got valid=%0b data=%0h expected valid=1 data=%0h",
                   out_valid, out_data, prev_data);
        end
      end
      if (out_valid && out_ready) begin
        beat_cnt++;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL extra_beat: got data=%0h expected no beat", out_data);
        end else begin
          exp_b = sb.pop_front();
          if (out_data !== exp_b) begin
            bad++;
            $display("FAIL beat_data: got %0h expected %0h", out_data, exp_b);
          end
        end
      end
      prev_stall = out_valid && !out_ready && !abort;
      prev_data  = out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic push_exp(input logic [11:0] base, input logic [12:0] len);
    logic [7:0] e;
    for (int i = 0; i < int'(len); i++) begin
      e = 8'((int'(base) + i) & 255);
      sb.push_back(e);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bit aborted;
    aborted = 1'b0;
    @(posedge clk); #1;
    base_addr = v.base; length = v.len; start = 1'b1; out_ready = (v.mode == 0);
    push_exp(v.base, v.len);
    beat_cnt = 0; done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b0;
    chk($sformatf("v%0d_busy_start", idx), busy, 1);
    for (int cyc = 0; cyc < 400 && busy; cyc++) begin
      case (v.mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc < 5) ? 1'b0 : cyc[0];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (v.abort_after >= 0 && beat_cnt == v.abort_after) begin
        abort = 1'b1; out_ready = 1'b0; aborted = 1'b1;
      end
      @(posedge clk); #1;
      if (aborted) begin
        abort = 1'b0;
        chk($sformatf("v%0d_abort_valid", idx), out_valid, 0);
        chk($sformatf("v%0d_abort_busy", idx), busy, 0);
      end
    end
    out_ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    chk($sformatf("v%0d_idle_timeout", idx), busy, 0);
    chk($sformatf("v%0d_beats", idx), beat_cnt, v.exp_beats);
    chk($sformatf("v%0d_done_cnt", idx), done_cnt, v.exp_done);
    if (aborted) sb.delete();
    else chk($sformatf("v%0d_sb_empty", idx), sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{12'h010, 13'd4,  0, -1, 4,  1};
    vecs[1] = '{12'hFFE, 13'd4,  0, -1, 4,  1};
    vecs[2] = '{12'h020, 13'd8,  1, -1, 8,  1};
    vecs[3] = '{12'h000, 13'd16, 0,  3, 3,  0};
    vecs[4] = '{12'h100, 13'd2,  0, -1, 2,  1};
    vecs[5] = '{12'h0F0, 13'd40, 2, -1, 40, 1};
    vecs[6] = '{12'hFFF, 13'd1,  1, -1, 1,  1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", addr_r, 0);
    chk("rst_data", out_data, 0);
    reset_n = 1'b1;

    // First-beat latency and done timing
    @(posedge clk); #1;
    base_addr = 12'h010; length = 13'd4; start = 1'b1; out_ready = 1'b1;
    push_exp(12'h010, 13'd4);
    beat_cnt = 0; done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("lat_e0_valid", out_valid, 0);
    chk("lat_e0_busy", busy, 1);
    @(posedge clk); #1;
    chk("lat_e1_valid", out_valid, 0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("lat_beat%0d_valid", k), out_valid, 1);
      chk($sformatf("lat_beat%0d_data", k), out_data, 32'h10 + k);
      chk($sformatf("lat_beat%0d_done", k), done, 0);
    end
    @(posedge clk); #1;
    chk("lat_done", done, 1);
    chk("lat_busy_end", busy, 0);
    chk("lat_valid_end", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_done_clear", done, 0);
    chk("lat_addr_hold", addr_r, 32'h013);
    chk("lat_beats", beat_cnt, 4);

    // Zero-length burst
    @(posedge clk); #1;
    base_addr = 12'h055; length = 13'd0; start = 1'b1;
    beat_cnt = 0; done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("zl_busy", busy, 1);
    chk("zl_done", done, 1);
    chk("zl_valid", out_valid, 0);
    @(posedge clk); #1;
    chk("zl_busy_end", busy, 0);
    chk("zl_done_end", done, 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("zl_done_cnt", done_cnt, 1);
    chk("zl_beats", beat_cnt, 0);

    // start together with abort in IDLE
    @(posedge clk); #1;
    base_addr = 12'h010; length = 13'd4; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", busy, 0);

    for (int v = 0; v < 7; v++) run_vec(vecs[v], v);

    // Reset mid-burst
    @(posedge clk); #1;
    base_addr = 12'h040; length = 13'd16; start = 1'b1; out_ready = 1'b1;
    push_exp(12'h040, 13'd16);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    mon_en = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_addr", addr_r, 0);
    chk("mrst_data", out_data, 0);
    sb.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    mon_en = 1'b1;
    run_vec('{12'h080, 13'd3, 0, -1, 3, 1}, 7);

    // start while busy is ignored
    @(posedge clk); #1;
    base_addr = 12'h200; length = 13'd6; start = 1'b1; out_ready = 1'b1;
    push_exp(12'h200, 13'd6);
    beat_cnt = 0; done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    base_addr = 12'h300; length = 13'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 50 && busy; c++) begin @(posedge clk); #1; end
    repeat (6) begin @(posedge clk); #1; end
    chk("sb_busy_end", busy, 0);
    chk("sb_beats", beat_cnt, 6);
    chk("sb_done_cnt", done_cnt, 1);
    chk("sb_queue_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
